lifo_rd_stream: RTL and testbench

Read-side adapter that sits directly downstream of the LIFO. It issues `rdreq` to the LIFO and absorbs the LIFO's one-cycle read latency in a 2-entry output buffer. It presents the popped words as a valid/ready stream, so downstream logic never deals with LIFO flags or read latency. Sustains one word per cycle while the LIFO is non-empty and the consumer is ready.

---
 rtl/lifo_pkg.sv | 15 +
 rtl/lifo_rd_skid.sv | 69 ++++++
 rtl/lifo_rd_stream.sv | 79 +++++++
 tb/tb_lifo_rd_stream.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lifo_pkg.sv
// lifo_pkg: types and constants shared by the LIFO read-side stream adapter.
package lifo_pkg;

  localparam int RD_BUF_DEPTH = 2;

  typedef logic [1:0] rd_occ_t;

  // True when one more word can be requested without overrunning the read buffer.
  function automatic logic rd_has_credit(rd_occ_t occ, logic inflight, logic pop);
    logic [2:0] committed;
    committed = ({1'b0, occ} + 3'(inflight)) - 3'(pop);
    return committed < 3'(RD_BUF_DEPTH);
  endfunction

endpackage

// File: rtl/lifo_rd_skid.sv
// lifo_rd_skid: 2-entry in-order buffer that absorbs the LIFO read latency.
module lifo_rd_skid
  import lifo_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              pop_i,
  output logic [DWIDTH-1:0] data_o,
  output rd_occ_t           occ_o
);

  logic [DWIDTH-1:0] mem [RD_BUF_DEPTH];
  logic              head;
  logic              tail;
  rd_occ_t           occ;
  rd_occ_t           occ_next;

  always_comb begin
    // NOTE: default assigned first so every path drives occ_next and no latch is inferred.
    occ_next = occ;
    if (push_i && !pop_i) begin
      occ_next = occ + 2'd1;
    end else if (pop_i && !push_i) begin
      occ_next = occ - 2'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      // NOTE: the two data entries are reset so the stream data reads 0 until the first capture.
      for (int i = 0; i < RD_BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
      head <= 1'b0;
      tail <= 1'b0;
      occ  <= '0;
    end else if (flush_i) begin
      head <= 1'b0;
      tail <= 1'b0;
      occ  <= '0;
    end else begin
      if (push_i) begin
        mem[tail] <= data_i;
        tail      <= ~tail;
      end
      if (pop_i) begin
        head <= ~head;
      end
      occ <= occ_next;
    end
  end

  assign data_o = mem[head];
  assign occ_o  = occ;

  // The credit rule upstream makes a capture into a full buffer impossible.
  a_no_overflow : assert property (@(posedge clk_i) disable iff (!arst_n_i)
    (push_i && !flush_i) |-> (occ != rd_occ_t'(RD_BUF_DEPTH)));

  a_no_underflow : assert property (@(posedge clk_i) disable iff (!arst_n_i)
    pop_i |-> (occ != '0));

endmodule

// File: rtl/lifo_rd_stream.sv
// lifo_rd_stream: issues LIFO reads and presents popped words as a valid/ready stream.
// Optional accepted-word counter pop_cnt_o is built when LIFO_RD_STREAM_CNT_EN is defined.
module lifo_rd_stream
  import lifo_pkg::*;
#(
  parameter int DWIDTH    = 8,
  parameter int AWIDTH    = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 arst_n_i,
  output logic                 lifo_rdreq_o,
  input  logic [DWIDTH-1:0]    lifo_q_i,
  input  logic                 lifo_empty_i,
  input  logic [AWIDTH:0]      lifo_usedw_i,
  input  logic                 flush_i,
  output logic [DWIDTH-1:0]    src_data_o,
  output logic                 src_valid_o,
  input  logic                 src_ready_i,
  output logic                 busy_o
`ifdef LIFO_RD_STREAM_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] pop_cnt_o
`endif
);

  rd_occ_t occ;
  logic    inflight;
  logic    pop;
  logic    capture;

  assign pop     = src_valid_o && src_ready_i;
  assign capture = inflight && !flush_i;

  // Reset gates the request combinationally so nothing is read while held in reset.
  assign lifo_rdreq_o = arst_n_i && !lifo_empty_i && (lifo_usedw_i != '0) && !flush_i
                        && rd_has_credit(occ, inflight, pop);

  // The request is low during a flush, so the in-flight word is dropped for free.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      inflight <= 1'b0;
    end else begin
      inflight <= lifo_rdreq_o;
    end
  end

  lifo_rd_skid #(
    .DWIDTH (DWIDTH)
  ) u_skid (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .flush_i  (flush_i),
    .push_i   (capture),
    .data_i   (lifo_q_i),
    .pop_i    (pop),
    .data_o   (src_data_o),
    .occ_o    (occ)
  );

  assign src_valid_o = (occ != '0);
  assign busy_o      = src_valid_o || inflight;

`ifdef LIFO_RD_STREAM_CNT_EN
  // Counts accepted words; only reset clears it, flush leaves it alone.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      pop_cnt_o <= '0;
    end else if (pop) begin
      pop_cnt_o <= pop_cnt_o + 1'b1;
    end
  end
`else
  // CNT_WIDTH stays in the parameter list so both builds share one instantiation.
  if (CNT_WIDTH < 1) begin : g_cnt_absent
  end
`endif

endmodule

// File: tb/tb_lifo_rd_stream.sv
// tb_lifo_rd_stream: scoreboard bench with a queue-based LIFO model driving lifo_rd_stream.
module tb_lifo_rd_stream;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int UW = AW + 1;
  localparam int CW = 4;
  localparam int LIFO_DEPTH = 1 << AW;

  logic          clk_i        = 1'b0;
  logic          arst_n_i     = 1'b1;
  logic          lifo_rdreq_o;
  logic [DW-1:0] lifo_q_i     = '0;
  logic          lifo_empty_i = 1'b1;
  logic [UW-1:0] lifo_usedw_i = '0;
  logic          flush_i      = 1'b0;
  logic [DW-1:0] src_data_o;
  logic          src_valid_o;
  logic          src_ready_i  = 1'b0;
  logic          busy_o;
`ifdef LIFO_RD_STREAM_CNT_EN
  logic [CW-1:0] pop_cnt_o;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] stack [$];
  logic [DW-1:0] wr_q  [$];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] rd_word;
  logic          rdreq_s   = 1'b0;
  logic          flush_s   = 1'b0;
  logic          hold_prev = 1'b0;
  logic [DW-1:0] prev_data = '0;
  int            n_pops    = 0;

  lifo_rd_stream #(
    .DWIDTH    (DW),
    .AWIDTH    (AW),
    .CNT_WIDTH (CW)
  ) dut (
    .clk_i        (clk_i),
    .arst_n_i     (arst_n_i),
    .lifo_rdreq_o (lifo_rdreq_o),
    .lifo_q_i     (lifo_q_i),
    .lifo_empty_i (lifo_empty_i),
    .lifo_usedw_i (lifo_usedw_i),
    .flush_i      (flush_i),
    .src_data_o   (src_data_o),
    .src_valid_o  (src_valid_o),
    .src_ready_i  (src_ready_i),
    .busy_o       (busy_o)
`ifdef LIFO_RD_STREAM_CNT_EN
    ,
    .pop_cnt_o    (pop_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // LIFO model: a read pops the top of the stack and q shows it the following cycle.
  // Every word read is owed to the stream unless a flush or reset discards it.
  always @(posedge clk_i) begin
    if (!arst_n_i) begin
      exp_q.delete();
    end else begin
      if (flush_s) exp_q.delete();
      if (rdreq_s && stack.size() > 0) begin
        rd_word = stack.pop_back();
        lifo_q_i <= rd_word;
        exp_q.push_back(rd_word);
      end
    end
    while (wr_q.size() > 0) stack.push_back(wr_q.pop_front());
    lifo_empty_i <= (stack.size() == 0);
    lifo_usedw_i <= UW'(stack.size());
  end

  // Monitor: samples mid-cycle, checks each accepted word against the scoreboard.
  always @(negedge clk_i) begin
    rdreq_s = lifo_rdreq_o;
    flush_s = flush_i;
    if (!arst_n_i) begin
      n_pops    = 0;
      hold_prev = 1'b0;
      check("rst_rdreq", lifo_rdreq_o, 0);
      check("rst_valid", src_valid_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_data", src_data_o, 0);
    end else begin
      check("rdreq_when_empty", lifo_rdreq_o && lifo_empty_i, 0);
      check("busy_vs_owed", busy_o, exp_q.size() != 0);
      check("credit_bound", exp_q.size() <= 2, 1);
      if (hold_prev) begin
        check("hold_valid", src_valid_o, 1);
        check("hold_data", src_data_o, prev_data);
      end
      if (src_valid_o && src_ready_i) begin
        n_pops++;
        check("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("word_order", src_data_o, exp_q.pop_front());
      end
      hold_prev = src_valid_o && !src_ready_i && !flush_i;
      prev_data = src_data_o;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] t1_exp [3];
    int  pulses;
    int  vcnt;
    int  seen;
    int  bad;
    bit  done;

    t1_exp = '{8'hC3, 8'hB2, 8'hA1};

    // Reset with three words loaded; release with ready high.
    #1 arst_n_i = 1'b0;
    tick();
    wr_q.push_back(8'hA1);
    wr_q.push_back(8'hB2);
    wr_q.push_back(8'hC3);
    tick();
    tick();
    arst_n_i    = 1'b1;
    src_ready_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      check($sformatf("t1_rdreq_c%0d", c), lifo_rdreq_o, c < 3);
      check($sformatf("t1_valid_c%0d", c), src_valid_o, (c >= 2) && (c <= 4));
      if (c >= 2 && c <= 4) check($sformatf("t1_data_c%0d", c), src_data_o, t1_exp[c-2]);
      if (c == 5) check("t1_busy_c5", busy_o, 0);
    end

    // Five words with backpressure: only two reads, then a gap-free drain.
    tick();
    src_ready_i = 1'b0;
    for (int i = 1; i <= 5; i++) wr_q.push_back(DW'(8'h10 + i));
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      pulses += int'(lifo_rdreq_o);
    end
    check("t2_rdreq_pulses", pulses, 2);
    check("t2_valid", src_valid_o, 1);
    check("t2_head", src_data_o, 8'h15);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      check("t2_data_stable", src_data_o, 8'h15);
    end
    tick();
    src_ready_i = 1'b1;
    vcnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      vcnt += int'(src_valid_o);
    end
    check("t2_drain_no_gaps", vcnt, 5);
    @(negedge clk_i);
    check("t2_drained", src_valid_o, 0);

    // Empty LIFO: no request and no valid regardless of ready.
    vcnt   = 0;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      src_ready_i = 1'($urandom_range(0, 1));
      @(negedge clk_i);
      pulses += int'(lifo_rdreq_o);
      vcnt   += int'(src_valid_o);
    end
    check("t3_no_rdreq", pulses, 0);
    check("t3_no_valid", vcnt, 0);

    // Flush with one word buffered and one in flight.
    tick();
    src_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) wr_q.push_back(DW'(8'h30 + i));
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge clk_i);
      if (src_valid_o) seen = 1;
    end
    check("t4_valid_seen", seen, 1);
    check("t4_busy_before", busy_o, 1);
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    @(negedge clk_i);
    check("t4_valid_after_flush", src_valid_o, 0);
    check("t4_busy_after_flush", busy_o, 0);
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      if (src_valid_o && src_data_o == 8'h32) bad++;
    end
    check("t4_dropped_word_absent", bad, 0);

    // Asynchronous reset with the buffer full.
    tick();
    src_ready_i = 1'b0;
    wr_q.push_back(8'h41);
    wr_q.push_back(8'h42);
    wr_q.push_back(8'h43);
    repeat (6) @(negedge clk_i);
    check("t5_full_valid", src_valid_o, 1);
    tick();
    src_ready_i = 1'b1;
    #1;
    check("t5_rdreq_pre_reset", lifo_rdreq_o, 1);
    #1 arst_n_i = 1'b0;
    #1;
    check("t5_valid_async", src_valid_o, 0);
    check("t5_rdreq_async", lifo_rdreq_o, 0);
    check("t5_busy_async", busy_o, 0);
    tick();
    tick();
    arst_n_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      check($sformatf("t5_valid_post_c%0d", c), src_valid_o, 0);
      check($sformatf("t5_data_post_c%0d", c), src_data_o, 0);
    end
    tick();
    for (int i = 0; i < 16; i++) wr_q.push_back(DW'(8'h50 + i));
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk_i);
      if (stack.size() == 0 && wr_q.size() == 0 && !busy_o) done = 1'b1;
    end
    check("t5_drain_done", done, 1);
    check("t5_accepted_17", n_pops, 17);
`ifdef LIFO_RD_STREAM_CNT_EN
    check("t6_pop_cnt_wrap", pop_cnt_o, 1);
`endif

    // Randomised traffic: writes, backpressure and occasional flushes.
    for (int c = 0; c < 800; c++) begin
      tick();
      src_ready_i = ($urandom_range(0, 3) != 0);
      flush_i     = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 2) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, 2)); k++) begin
          if (stack.size() + wr_q.size() < LIFO_DEPTH - 1) wr_q.push_back(DW'($urandom));
        end
      end
    end

    tick();
    flush_i     = 1'b0;
    src_ready_i = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk_i);
      if (stack.size() == 0 && wr_q.size() == 0 && !busy_o) done = 1'b1;
    end
    check("final_drain_done", done, 1);
    check("final_scoreboard_empty", exp_q.size(), 0);
`ifdef LIFO_RD_STREAM_CNT_EN
    check("final_pop_cnt", pop_cnt_o, CW'(n_pops));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
